// File: rtl/upload_packer.sv
// ---------------------------------------------------------------------------
// upload_packer
//
// Buffers the payload bytes streamed by the upstream I2C read handler.
// When the stream ends, it emits them as one framed packet:
//   SYNC0, SYNC1, source, count[15:8], count[7:0], payload..., [checksum]
//
// Build option:
//   UPLOAD_PACKER_CHECKSUM_EN - when defined, a modulo-256 checksum byte is
//                               appended after the payload (CSUM state).
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   upload_active  in   high while the upstream handler is streaming
//   upload_req     in   upstream byte request (informational only)
//   upload_data    in   payload byte
//   upload_source  in   source ID of the payload byte
//   upload_valid   in   strobe qualifying upload_data/upload_source
//   upload_ready   out  high when a byte can be accepted
//   pack_data      out  framed output byte
//   pack_valid     out  qualifies pack_data
//   pack_ready     in   downstream accept
//   frame_done     out  one-cycle pulse after the last frame byte is accepted
//   overflow       out  sticky flag, set when a payload byte is dropped
// ---------------------------------------------------------------------------
module upload_packer #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [7:0]  SYNC0      = 8'hAA,
    parameter logic [7:0]  SYNC1      = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upload_active,
    input  logic       upload_req,
    input  logic [7:0] upload_data,
    input  logic [7:0] upload_source,
    input  logic       upload_valid,
    output logic       upload_ready,
    output logic [7:0] pack_data,
    output logic       pack_valid,
    input  logic       pack_ready,
    output logic       frame_done,
    output logic       overflow
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DEPTH16 = 16'(FIFO_DEPTH);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_COLLECT = 4'd1;
    localparam logic [3:0] ST_SYNC0   = 4'd2;
    localparam logic [3:0] ST_SYNC1   = 4'd3;
    localparam logic [3:0] ST_SRC     = 4'd4;
    localparam logic [3:0] ST_LEN_H   = 4'd5;
    localparam logic [3:0] ST_LEN_L   = 4'd6;
    localparam logic [3:0] ST_DATA    = 4'd7;
`ifdef UPLOAD_PACKER_CHECKSUM_EN
    localparam logic [3:0] ST_CSUM    = 4'd8;
`endif

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [15:0]   count_q;
    logic [15:0]   sent_q;
    logic [7:0]    source_q;
    logic          overflow_q;
    logic          frameDone_q;
    logic [7:0]    fifoMem_q [FIFO_DEPTH];
`ifdef UPLOAD_PACKER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic collecting;
    logic full;
    logic accept;
    logic drop;
    logic handshake;
    logic lastPayload;
    logic frameEnd;

    // upload_req carries no control meaning here; it is only tied off.
    logic unusedReq;
    assign unusedReq = upload_req;

    // Input side is open only while gathering payload; reset holds it closed.
    assign collecting   = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign full         = (count_q == DEPTH16);
    assign upload_ready = !rst && collecting && !full;
    assign accept       = upload_valid && upload_ready;
    assign drop         = upload_valid && !upload_ready && collecting;

    // Every non-collecting state presents a frame byte.
    assign pack_valid  = !collecting;
    assign handshake   = pack_valid && pack_ready;
    assign lastPayload = (sent_q == count_q - 16'd1);
    assign frame_done  = frameDone_q;
    assign overflow    = overflow_q;

    // Next-state logic: collection ends on falling upload_active (only once at
    // least one byte exists), then each emit state advances on a handshake.
    always_comb begin
        state_d  = state_q;
        frameEnd = 1'b0;
        case (state_q)
            ST_IDLE:    if (accept)         state_d = ST_COLLECT;
            ST_COLLECT: if (!upload_active) state_d = ST_SYNC0;
            ST_SYNC0:   if (handshake)      state_d = ST_SYNC1;
            ST_SYNC1:   if (handshake)      state_d = ST_SRC;
            ST_SRC:     if (handshake)      state_d = ST_LEN_H;
            ST_LEN_H:   if (handshake)      state_d = ST_LEN_L;
            ST_LEN_L:   if (handshake)      state_d = ST_DATA;
            ST_DATA: begin
                if (handshake && lastPayload) begin
`ifdef UPLOAD_PACKER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d  = ST_IDLE;
                    frameEnd = 1'b1;
`endif
                end
            end
`ifdef UPLOAD_PACKER_CHECKSUM_EN
            ST_CSUM: begin
                if (handshake) begin
                    state_d  = ST_IDLE;
                    frameEnd = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output byte selection; idle/collect present zero.
    always_comb begin
        pack_data = 8'h00;
        case (state_q)
            ST_SYNC0: pack_data = SYNC0;
            ST_SYNC1: pack_data = SYNC1;
            ST_SRC:   pack_data = source_q;
            ST_LEN_H: pack_data = count_q[15:8];
            ST_LEN_L: pack_data = count_q[7:0];
            ST_DATA:  pack_data = fifoMem_q[rdPtr_q];
`ifdef UPLOAD_PACKER_CHECKSUM_EN
            ST_CSUM:  pack_data = csum_q + source_q + count_q[15:8] + count_q[7:0];
`endif
            default:  pack_data = 8'h00;
        endcase
    end

    // Payload storage has no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifoMem_q[wrPtr_q] <= upload_data;
        end
    end

    // Control state, FIFO pointers, byte count and flags. The end of a frame
    // clears pointers and counters so the next frame starts from slot zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            sent_q      <= '0;
            source_q    <= '0;
            overflow_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frameDone_q <= frameEnd;
            if (accept) begin
                wrPtr_q <= wrPtr_q + AW'(1);
                count_q <= count_q + 16'd1;
                if (state_q == ST_IDLE) begin
                    source_q <= upload_source;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (accept && (state_q == ST_IDLE)) begin
                overflow_q <= 1'b0;
            end
            if (handshake && (state_q == ST_DATA)) begin
                rdPtr_q <= rdPtr_q + AW'(1);
                sent_q  <= sent_q + 16'd1;
            end
            if (frameEnd) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
                sent_q  <= '0;
            end
        end
    end

`ifdef UPLOAD_PACKER_CHECKSUM_EN
    // Running payload sum; header bytes are folded in when CSUM is presented.
    always_ff @(posedge clk) begin
        if (rst || frameEnd) begin
            csum_q <= 8'h00;
        end else if (accept) begin
            csum_q <= csum_q + upload_data;
        end
    end
`endif

endmodule

// File: tb/tb_upload_packer.sv
// ---------------------------------------------------------------------------
// tb_upload_packer
//
// Bench for upload_packer built with FIFO_DEPTH=4 so that overflow is easy to
// reach. Follows UPLOAD_PACKER_CHECKSUM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_upload_packer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       upload_active;
    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] pack_data;
    logic       pack_valid;
    logic       pack_ready;
    logic       frame_done;
    logic       overflow;

    upload_packer #(
        .FIFO_DEPTH(DEPTH),
        .SYNC0     (8'hAA),
        .SYNC1     (8'h55)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .upload_active(upload_active),
        .upload_req   (upload_req),
        .upload_data  (upload_data),
        .upload_source(upload_source),
        .upload_valid (upload_valid),
        .upload_ready (upload_ready),
        .pack_data    (pack_data),
        .pack_valid   (pack_valid),
        .pack_ready   (pack_ready),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    bit doneNext = 1'b0;
    bit doneNow = 1'b0;
    bit modelOverflow = 1'b0;

    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    logic [7:0] modelPay[$];
    logic [7:0] stimQ[$];
    logic [7:0] litQ[$];
    logic       readyLog[$];

    // Single comparison point used by every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Compares the captured output bytes with a literal frame.
    task automatic checkSeq(input string name);
        checkOutput({name, "Len"}, 32'(gotQ.size()), 32'(litQ.size()));
        for (int i = 0; i < litQ.size(); i++) begin
            if (i < gotQ.size()) checkOutput(name, 32'(gotQ[i]), 32'(litQ[i]));
        end
    endtask

    // Builds the frame the collected payload must produce.
    task automatic pushFrame(input logic [7:0] src);
        int len;
        int sum;
        len = modelPay.size();
        expQ.push_back(8'hAA);
        expQ.push_back(8'h55);
        expQ.push_back(src);
        expQ.push_back(8'(len / 256));
        expQ.push_back(8'(len % 256));
        sum = int'(src) + len / 256 + len % 256;
        foreach (modelPay[k]) begin
            expQ.push_back(modelPay[k]);
            sum += int'(modelPay[k]);
        end
`ifdef UPLOAD_PACKER_CHECKSUM_EN
        expQ.push_back(8'(sum % 256));
`endif
    endtask

    // Output watcher: while a frame is owed, every cycle must present its next
    // byte; otherwise pack_valid must stay low. frame_done must pulse exactly
    // one cycle after the final byte is taken.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            doneNext = 1'b0;
        end else begin
            doneNow = 1'b0;
            checkOutput("packValid", 32'(pack_valid), 32'(expQ.size() != 0));
            if (pack_valid && expQ.size() != 0) begin
                checkOutput("packData", 32'(pack_data), 32'(expQ[0]));
                if (pack_ready) begin
                    gotQ.push_back(pack_data);
                    void'(expQ.pop_front());
                    if (expQ.size() == 0) doneNow = 1'b1;
                end
            end
            checkOutput("frameDone", 32'(frame_done), 32'(doneNext));
            if (frame_done) doneCount++;
            doneNext = doneNow;
        end
    end

    // Synchronous reset; optionally checks the reset-state outputs.
    task automatic applyReset(input bit check);
        @(posedge clk);
        #1;
        rst = 1'b1;
        upload_valid = 1'b0;
        upload_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            checkOutput("rstPackValid", 32'(pack_valid), 0);
            checkOutput("rstPackData", 32'(pack_data), 0);
            checkOutput("rstFrameDone", 32'(frame_done), 0);
            checkOutput("rstOverflow", 32'(overflow), 0);
            checkOutput("rstReady", 32'(upload_ready), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (check) checkOutput("readyAfterRst", 32'(upload_ready), 1);
        modelPay.delete();
        modelOverflow = 1'b0;
    endtask

    // Streams stimQ from source src, ends the stream, then drains the frame.
    // readyMode: 0 = pack_ready high, 1 = toggling, 2 = random.
    // together: drop upload_active with the last byte.
    // abortAfter: if nonzero, reset once that many frame bytes were taken.
    task automatic applyStimulus(input logic [7:0] src, input int readyMode,
                                 input bit together, input bit gaps, input int abortAfter);
        int  n;
        int  startDone;
        bit  finished;
        bit  expReady;
        n = stimQ.size();
        gotQ.delete();
        modelPay.delete();
        readyLog.delete();
        @(posedge clk);
        #1;
        upload_active = 1'b1;
        upload_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
                upload_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            upload_valid = 1'b1;
            upload_data = stimQ[i];
            upload_source = (i == 0) ? src : 8'($urandom);
            upload_req = 1'($urandom);
            pack_ready = 1'($urandom);
            if (together && i == n - 1) upload_active = 1'b0;
            @(negedge clk);
            expReady = (modelPay.size() < DEPTH);
            readyLog.push_back(upload_ready);
            checkOutput("uploadReady", 32'(upload_ready), 32'(expReady));
            if (expReady) begin
                if (modelPay.size() == 0) modelOverflow = 1'b0;
                modelPay.push_back(stimQ[i]);
            end else begin
                modelOverflow = 1'b1;
            end
        end
        if (!together) begin
            @(posedge clk);
            #1;
            upload_valid = 1'b0;
            upload_active = 1'b0;
        end
        @(posedge clk);
        startDone = doneCount;
        if (modelPay.size() != 0) pushFrame(src);
        #1;
        upload_valid = 1'b0;
        if (modelPay.size() != 0) begin
            finished = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk);
                #1;
                case (readyMode)
                    0:       pack_ready = 1'b1;
                    1:       pack_ready = (c % 2 == 0);
                    default: pack_ready = 1'($urandom);
                endcase
                if (abortAfter > 0 && gotQ.size() >= abortAfter) begin
                    applyReset(1'b1);
                    finished = 1'b1;
                    break;
                end
                if (doneCount != startDone) begin
                    finished = 1'b1;
                    break;
                end
            end
            checks++;
            if (!finished) begin
                errors++;
                $display("[TB] FAIL frameTimeout: got no frame_done, expected one within 400 cycles");
                applyReset(1'b0);
            end
        end else begin
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
        checkOutput("overflow", 32'(overflow), 32'(modelOverflow));
    endtask

    initial begin
        int n;
        int startDone;
        rst = 1'b1;
        upload_active = 1'b0;
        upload_req = 1'b0;
        upload_valid = 1'b0;
        upload_data = 8'h00;
        upload_source = 8'h00;
        pack_ready = 1'b0;

        applyReset(1'b1);

        // Three-byte frame, downstream always ready.
        stimQ = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h05, 0, 1'b0, 1'b0, 0);
        litQ = '{8'hAA, 8'h55, 8'h05, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef UPLOAD_PACKER_CHECKSUM_EN
        litQ.push_back(8'h6E);
`endif
        checkSeq("frame3");

        // Downstream toggling every cycle.
        stimQ = '{8'h01, 8'hFE, 8'h80, 8'h7F};
        applyStimulus(8'h9A, 1, 1'b1, 1'b0, 0);

        // Six bytes into a four-deep FIFO.
        stimQ = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        applyStimulus(8'h3C, 0, 1'b0, 1'b0, 0);
        litQ = '{8'hAA, 8'h55, 8'h3C, 8'h00, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
`ifdef UPLOAD_PACKER_CHECKSUM_EN
        litQ.push_back(8'hCA);
`endif
        checkSeq("overflowFrame");
        checkOutput("overflowFlag", 32'(overflow), 1);
        checkOutput("readyByte4", 32'(readyLog[3]), 1);
        checkOutput("readyByte5", 32'(readyLog[4]), 0);

        // upload_active pulse with no data: no frame at all.
        startDone = doneCount;
        stimQ.delete();
        applyStimulus(8'h77, 0, 1'b0, 1'b0, 0);
        checkOutput("emptyDone", 32'(doneCount), 32'(startDone));
        checkOutput("emptyBytes", 32'(gotQ.size()), 0);

        // Reset in the middle of the payload, then a clean one-byte frame.
        stimQ = '{8'h61, 8'h62, 8'h63};
        applyStimulus(8'h05, 0, 1'b0, 1'b0, 6);
        stimQ = '{8'h42};
        applyStimulus(8'h05, 0, 1'b0, 1'b0, 0);
        litQ = '{8'hAA, 8'h55, 8'h05, 8'h00, 8'h01, 8'h42};
`ifdef UPLOAD_PACKER_CHECKSUM_EN
        litQ.push_back(8'h48);
`endif
        checkSeq("afterReset");

        // Randomized streams.
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, 6);
            stimQ.delete();
            for (int i = 0; i < n; i++) stimQ.push_back(8'($urandom));
            applyStimulus(8'($urandom), $urandom_range(0, 2),
                          (n >= 2) && ($urandom_range(0, 1) == 1),
                          $urandom_range(0, 1) == 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
